jt6295_fetch: RTL and testbench
===============================

JT6295_FETCH -- requirements
Module: jt6295_fetch

Interface
REQ-001 SHALL have parameter CH, default 4, the number of time-multiplexed channels (fixed at 4; any other value is unsupported).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have port cen, input, 1, the channel-slot enable; each cen is one channel slot.
REQ-005 SHALL have port start, input, 4, the one-hot per-channel play request, sampled on cen.
REQ-006 SHALL have port stop, input, 4, the one-hot per-channel stop request, sampled on cen.
REQ-007 SHALL have port start_addr, input, 18, the first byte address of a requested sample.
REQ-008 SHALL have port stop_addr, input, 18, the last byte address (inclusive) of a requested sample.
REQ-009 SHALL have port start_att, input, 4, the attenuation code latched on start.
REQ-010 SHALL have ports rom_cs (output, 1), rom_addr (output, 18), rom_data (input, 8) and rom_ok (input, 1), forming the ROM request port.
REQ-011 SHALL have ports data (output, 4), en (output, 1) and att (output, 4), forming the decoder feed for the current slot.
REQ-012 SHALL have port busy, output, 4, per-channel playing flags.

Function
REQ-013 SHALL hold a 2-bit slot counter ch, incremented modulo 4 on each clk where cen=1.
REQ-014 SHALL register data, en and att on each clk with cen=1, driven from the state of channel ch; outputs are valid from the following clk until the next cen.
REQ-015 SHALL keep, per channel, a 19-bit nibble pointer (byte address in [18:1], nibble select in bit 0), an 8-bit byte buffer, a buf_valid flag, a 4-bit att value and a busy flag.
REQ-016 SHALL, on start[k] at cen, load the pointer from {start_addr,0}, latch stop_addr and start_att, set busy[k], and clear buf_valid[k]; a start on a busy channel restarts that channel.
REQ-017 SHALL give stop priority when start[k] and stop[k] are asserted together: the channel goes idle.
REQ-018 SHALL, in the slot of an idle channel, output en=0, data=0 and att=0.
REQ-019 SHALL, in the slot of a busy channel with buf_valid=1, output en=1 and att=att[k], with data equal to the high nibble when pointer bit 0=0 and the low nibble otherwise; the pointer then increments.
REQ-020 SHALL clear buf_valid[k] after the low nibble is output.
REQ-021 SHALL clear busy[k] after the low nibble of byte stop_addr is output, and SHALL NOT issue a further fetch for that channel.
REQ-022 SHALL treat a busy slot with buf_valid=0 as an underrun: en=1, data=4'b0000, pointer unchanged.
REQ-023 SHALL implement the fetch FSM with states IDLE, REQ and LOAD:
- IDLE -> REQ when any busy channel has buf_valid=0; the channel is chosen round-robin starting after the last channel served.
- REQ drives rom_cs=1 with rom_addr held stable until rom_ok=1, then goes to LOAD.
- LOAD writes rom_data to the byte buffer, sets buf_valid, then returns to IDLE.
REQ-024 SHALL discard a fetch whose channel was restarted or stopped while in REQ: buf_valid stays 0 and the FSM returns to IDLE.
REQ-025 SHALL wrap rom_addr modulo 2^18, and SHALL end playback at stop_addr even when stop_addr is less than start_addr (wrapped).

Reset
REQ-026 SHALL, with rst_n=0 at a clk edge, clear ch, all busy and buf_valid flags, the pointers, att and the FSM (to IDLE); all outputs SHALL read 0.
REQ-027 SHALL abandon any in-flight ROM request on reset (rom_cs=0 on the next clk).

Configuration
REQ-028 SHALL, with JT6295_FETCH_DEBUG_EN defined, add output underrun_cnt[7:0], which increments once per underrun slot, saturates at 255 and is cleared by reset.
REQ-029 SHALL have no underrun_cnt port when JT6295_FETCH_DEBUG_EN is not defined; behaviour is otherwise identical.

Structure
REQ-030 SHALL take the constants CH=4, ADDR_W=18 and the FSM state enum from the package jt6295_pkg.
REQ-031 SHALL place the round-robin channel selection in the sub-module jt6295_rr_arb (4 requests in, one-hot grant and index out).

Verification
REQ-032 Single play: start[0] with start_addr=0x100, stop_addr=0x101, ROM bytes 0x12 and 0x34, rom_ok 2 clk after rom_cs -> channel 0 slots output data 1,2,3,4 with en=1, then en=0 and busy[0]=0.
REQ-033 Four channels: all start at distinct addresses with rom_ok latency 1 -> no underrun; every slot shows its own channel's att.
REQ-034 Slow ROM: rom_ok latency 20 clk with cen every 4 clk -> underrun slots output en=1 and data=0; with JT6295_FETCH_DEBUG_EN, underrun_cnt matches the number of such slots.
REQ-035 Stop mid-sample, and start+stop in the same cen on channel 2 -> busy[2]=0 and en=0 from the next channel-2 slot; an in-flight fetch is discarded.
REQ-036 Wrap: start_addr=0x3FFFF, stop_addr=0x00000 -> rom_addr sequence 0x3FFFF, 0x00000, then playback ends.
REQ-037 Reset asserted during REQ -> rom_cs=0 and busy=0 on the next clk; outputs stay 0 until a new start.

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared constants, fetch FSM states and nibble helper for the ADPCM fetch block.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package jt6295_pkg;

  localparam int CH     = 4;
  localparam int ADDR_W = 18;
  localparam int PTR_W  = ADDR_W + 1;  // byte address plus nibble select in bit 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } fetch_st_e;

  // High nibble is played first, then the low nibble of the same byte.
  function automatic logic [3:0] sel_nibble(input logic [7:0] b, input logic lo);
    return lo ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/jt6295_rr_arb.sv
// Round-robin pick among channels that need a ROM byte; search starts after the last winner.
// Latency: combinational grant; the last-winner pointer updates on adv.
// Backpressure: the grant is held, without advancing, until the caller asserts adv.
module jt6295_rr_arb
  import jt6295_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] req,
  input  logic          adv,
  output logic [CH-1:0] gnt,
  output logic [1:0]    idx,
  output logic          any
);

  logic [1:0] last;
  logic [1:0] cand;

  // Scan the requests in order last+1, last+2, ... and take the first one set.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < CH; i++) begin
      cand = last + 2'(i + 1);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  // Remember who was served; reset so that channel 0 goes first.
  always_ff @(posedge clk) begin
    if (!rst_n) last <= 2'(CH - 1);
    else if (adv) last <= idx;
  end

endmodule

// File: rtl/jt6295.sv
// Four-channel time-multiplexed ADPCM nibble fetcher with a shared single-request ROM port.
// Latency: data/en/att registered on the cen of a channel slot; ROM byte usable two clk after rom_ok.
// Backpressure: a slow ROM (rom_ok late) causes underrun slots (en=1, data=0), never a stall.
// Optional JT6295_FETCH_DEBUG_EN adds a saturating underrun_cnt output.
module jt6295_fetch #(
  parameter int CH = jt6295_pkg::CH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cen,
  input  logic [CH-1:0]                 start,
  input  logic [CH-1:0]                 stop,
  input  logic [jt6295_pkg::ADDR_W-1:0] start_addr,
  input  logic [jt6295_pkg::ADDR_W-1:0] stop_addr,
  input  logic [3:0]                    start_att,
  output logic                          rom_cs,
  output logic [jt6295_pkg::ADDR_W-1:0] rom_addr,
  input  logic [7:0]                    rom_data,
  input  logic                          rom_ok,
  output logic [3:0]                    data,
  output logic                          en,
  output logic [3:0]                    att,
  output logic [CH-1:0]                 busy
`ifdef JT6295_FETCH_DEBUG_EN
  ,
  output logic [7:0]                    underrun_cnt
`endif
);

  import jt6295_pkg::*;

  // Per-channel playback state
  logic [1:0]        ch;
  logic [PTR_W-1:0]  ptr    [CH];
  logic [ADDR_W-1:0] stop_q [CH];
  logic [7:0]        buf_q  [CH];
  logic [3:0]        att_q  [CH];
  logic [CH-1:0]     buf_valid;

  // Fetch engine
  fetch_st_e  st, st_nx;
  logic [1:0] fch;
  logic [7:0] fdata;
  logic       arb_adv, arb_any, load_ok;
  logic [1:0] arb_idx;
  logic [CH-1:0] arb_req, arb_gnt;

  // Start/stop only act on cen; stop wins over start.
  logic [CH-1:0] kill, go;
  assign kill = cen ? (start | stop) : '0;
  assign go   = cen ? (start & ~stop) : '0;

  // Decode of the channel owning the current slot
  logic slot_busy, slot_hit, slot_lo, slot_last;
  assign slot_busy = busy[ch];
  assign slot_hit  = slot_busy & buf_valid[ch];
  assign slot_lo   = ptr[ch][0];
  assign slot_last = slot_hit & slot_lo & (ptr[ch][PTR_W-1:1] == stop_q[ch]);

  // A channel being started/stopped this clk is not eligible, so the latched
  // address can never be stale by the time the request goes out.
  assign arb_req = busy & ~buf_valid & ~kill;

  jt6295_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .adv   (arb_adv),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Fetch FSM next state and ROM strobe
  always_comb begin
    st_nx   = st;
    rom_cs  = 1'b0;
    arb_adv = 1'b0;
    load_ok = 1'b0;
    case (st)
      IDLE: begin
        if (arb_any) begin
          arb_adv = 1'b1;
          st_nx   = REQ;
        end
      end
      REQ: begin
        rom_cs = 1'b1;
        if (kill[fch])   st_nx = IDLE;  // channel restarted/stopped: drop the fetch
        else if (rom_ok) st_nx = LOAD;
      end
      LOAD: begin
        load_ok = ~kill[fch];
        st_nx   = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // Fetch FSM state, target channel, held ROM address and captured byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      fch      <= '0;
      rom_addr <= '0;
      fdata    <= '0;
    end else begin
      st <= st_nx;
      if (arb_adv) begin
        fch <= arb_idx;
        for (int k = 0; k < CH; k++)
          if (arb_gnt[k]) rom_addr <= ptr[k][PTR_W-1:1];
      end
      if (st == REQ && rom_ok) fdata <= rom_data;
    end
  end

  // Channel state: slot consumption, buffer fill, then start/stop overrides
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= '0;
      buf_valid <= '0;
      for (int k = 0; k < CH; k++) begin
        ptr[k]    <= '0;
        stop_q[k] <= '0;
        buf_q[k]  <= '0;
        att_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (cen && ch == 2'(k) && slot_hit) begin
          ptr[k] <= ptr[k] + PTR_W'(1);
          if (slot_lo)   buf_valid[k] <= 1'b0;
          if (slot_last) busy[k]      <= 1'b0;
        end
        if (load_ok && fch == 2'(k)) begin
          buf_q[k]     <= fdata;
          buf_valid[k] <= 1'b1;
        end
        if (kill[k]) begin
          busy[k]      <= go[k];
          buf_valid[k] <= 1'b0;
          if (go[k]) begin
            ptr[k]    <= {start_addr, 1'b0};
            stop_q[k] <= stop_addr;
            att_q[k]  <= start_att;
          end
        end
      end
    end
  end

  // Slot counter and registered decoder feed for the current slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch   <= '0;
      data <= '0;
      en   <= 1'b0;
      att  <= '0;
    end else if (cen) begin
      ch   <= ch + 2'd1;
      en   <= slot_busy;
      att  <= slot_busy ? att_q[ch] : 4'd0;
      data <= slot_hit ? sel_nibble(buf_q[ch], slot_lo) : 4'd0;
    end
  end

`ifdef JT6295_FETCH_DEBUG_EN
  // Count busy slots that found no byte ready, saturating at 255
  always_ff @(posedge clk) begin
    if (!rst_n) underrun_cnt <= '0;
    else if (cen && slot_busy && !buf_valid[ch] && underrun_cnt != 8'hFF)
      underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_jt6295_fetch.sv
// Self-checking bench for jt6295_fetch: directed scenarios plus random start/stop traffic,
// scored against a per-channel playback model (pointer, stop byte, att, busy).
// ROM model answers after a programmable latency; every ROM byte has two non-zero nibbles.
module tb_jt6295_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [3:0]  start = '0, stop = '0;
  logic [17:0] start_addr = '0, stop_addr = '0;
  logic [3:0]  start_att = '0;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;
  logic [3:0]  data;
  logic        en;
  logic [3:0]  att;
  logic [3:0]  busy;
`ifdef JT6295_FETCH_DEBUG_EN
  logic [7:0]  underrun_cnt;
`endif

  always #5 clk = ~clk;

  jt6295_fetch #(.CH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .start      (start),
    .stop       (stop),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .start_att  (start_att),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .data       (data),
    .en         (en),
    .att        (att),
    .busy       (busy)
`ifdef JT6295_FETCH_DEBUG_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ROM contents: two known bytes at 0x100/0x101, elsewhere nibbles in 1..15
  function automatic logic [7:0] rom_byte(input logic [17:0] a);
    int ai;
    logic [7:0] r;
    ai = int'(a);
    if (a == 18'h00100) return 8'h12;
    if (a == 18'h00101) return 8'h34;
    r[7:4] = 4'(1 + (ai * 7) % 15);
    r[3:0] = 4'(1 + (ai * 13 + 5) % 15);
    return r;
  endfunction

  // ROM responder: rom_ok after rom_lat clocks of rom_cs
  int          rom_lat = 2;
  int          rom_cnt = 0;
  logic [17:0] req_addr = '0;
  logic [17:0] acc_q[$];

  always @(negedge clk) begin
    if (rom_cs) begin
      if (rom_cnt == 0) req_addr = rom_addr;
      rom_cnt++;
      rom_ok   = (rom_cnt >= rom_lat);
      rom_data = rom_ok ? rom_byte(rom_addr) : 8'h00;
      if (rom_ok) chk("rom_addr_stable", rom_addr, req_addr);
    end else begin
      rom_cnt = 0;
      rom_ok  = 1'b0;
    end
  end

  always @(posedge clk)
    if (rst_n && rom_cs && rom_ok) acc_q.push_back(rom_addr);

  // Reference model: what each channel still has to play
  logic [18:0] m_ptr  [4];
  logic [17:0] m_stop [4];
  logic [3:0]  m_att  [4];
  logic [3:0]  m_busy = '0;
  int          m_ch = 0;
  int          m_urun = 0;
  bit          log_on = 1'b0;
  int          log0[$];

  task automatic model_slot(input logic [3:0] st, input logic [3:0] sp,
                            input logic [17:0] sa, input logic [17:0] ea, input logic [3:0] at);
    int s;
    logic [7:0] b;
    logic [3:0] nib;
    s = m_ch;
    m_ch = (m_ch + 1) % 4;
    if (log_on && s == 0) log0.push_back(int'({en, data}));
    if (!m_busy[s]) begin
      chk("idle_en", en, 1'b0);
      chk("idle_data", data, 4'h0);
      chk("idle_att", att, 4'h0);
    end else begin
      chk("busy_en", en, 1'b1);
      chk("slot_att", att, m_att[s]);
      if (data == 4'h0) begin
        m_urun++;
      end else begin
        b   = rom_byte(m_ptr[s][18:1]);
        nib = m_ptr[s][0] ? b[3:0] : b[7:4];
        chk("nibble", data, nib);
        if (m_ptr[s][0] && m_ptr[s][18:1] == m_stop[s]) m_busy[s] = 1'b0;
        m_ptr[s] = m_ptr[s] + 19'd1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (sp[k]) m_busy[k] = 1'b0;
      else if (st[k]) begin
        m_busy[k] = 1'b1;
        m_ptr[k]  = {sa, 1'b0};
        m_stop[k] = ea;
        m_att[k]  = at;
      end
    end
    chk("busy", busy, m_busy);
`ifdef JT6295_FETCH_DEBUG_EN
    chk("underrun_cnt", underrun_cnt, (m_urun > 255) ? 255 : m_urun);
`endif
  endtask

  // One channel slot: gap idle clocks, then a cen clock carrying start/stop
  task automatic do_slot(input int gap, input logic [3:0] st, input logic [3:0] sp,
                         input logic [17:0] sa, input logic [17:0] ea, input logic [3:0] at);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    cen = 1'b1; start = st; stop = sp;
    start_addr = sa; stop_addr = ea; start_att = at;
    @(posedge clk);
    #1;
    model_slot(st, sp, sa, ea, at);
    cen = 1'b0; start = '0; stop = '0;
  endtask

  task automatic drain(input int gap);
    int n;
    n = 0;
    while (m_busy != 4'h0 && n < 600) begin
      do_slot(gap, '0, '0, '0, '0, '0);
      n++;
    end
    do_slot(gap, '0, '0, '0, '0, '0);
    chk("drain_busy", busy, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cen = 1'b0; start = '0; stop = '0;
    @(posedge clk);
    #1;
    chk("rst_rom_cs", rom_cs, 1'b0);
    chk("rst_busy", busy, 4'h0);
    chk("rst_en", en, 1'b0);
    chk("rst_data", data, 4'h0);
    chk("rst_att", att, 4'h0);
`ifdef JT6295_FETCH_DEBUG_EN
    chk("rst_underrun_cnt", underrun_cnt, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = '0; m_ch = 0; m_urun = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_log[6];
    int u0, n, k, len;
    logic [17:0] sa;
    logic [3:0]  bits;
    exp_log = '{0, 'h11, 'h12, 'h13, 'h14, 0};

    repeat (3) @(posedge clk);
    do_reset();

    // Single play of 0x100..0x101 on channel 0
    rom_lat = 2;
    log0.delete();
    log_on = 1'b1;
    do_slot(3, 4'b0001, 4'b0000, 18'h00100, 18'h00101, 4'h5);
    for (int i = 0; i < 23; i++) do_slot(3, '0, '0, '0, '0, '0);
    log_on = 1'b0;
    chk("single_len", log0.size() >= 6, 1'b1);
    if (log0.size() >= 6)
      for (int i = 0; i < 6; i++) chk("single_seq", log0[i], exp_log[i]);
    chk("single_busy_end", busy[0], 1'b0);

    // Address wrap from 0x3FFFF to 0x00000
    acc_q.delete();
    do_slot(3, 4'b0010, 4'b0000, 18'h3FFFF, 18'h00000, 4'h9);
    drain(3);
    chk("wrap_fetches", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      chk("wrap_addr0", acc_q[0], 18'h3FFFF);
      chk("wrap_addr1", acc_q[1], 18'h00000);
    end

    // Four channels, fast ROM: no underruns, each slot carries its own att
    rom_lat = 1;
    u0 = m_urun;
    for (int c = 0; c < 4; c++) begin
      n = 0;
      while (m_ch != c && n < 8) begin
        do_slot(3, '0, '0, '0, '0, '0);
        n++;
      end
      sa = 18'(c * 18'h01000 + 18'h40);
      do_slot(3, 4'(1 << c), 4'b0000, sa, sa + 18'd3, 4'(c + 4'd10));
    end
    drain(3);
    chk("four_no_underrun", m_urun - u0, 0);

    // Slow ROM: underruns must appear and be zero-data slots
    rom_lat = 20;
    u0 = m_urun;
    do_slot(3, 4'b0001, 4'b0000, 18'h02000, 18'h02002, 4'h7);
    drain(3);
    chk("slow_underrun_seen", (m_urun - u0) > 0, 1'b1);

    // Stop channel 2 while its fetch is in flight, then restart elsewhere
    do_slot(3, 4'b0100, 4'b0000, 18'h03000, 18'h03013, 4'h2);
    do_slot(3, '0, '0, '0, '0, '0);
    chk("inflight_seen", rom_cs, 1'b1);
    do_slot(3, 4'b0000, 4'b0100, '0, '0, '0);
    chk("stop_busy2", busy[2], 1'b0);
    for (int i = 0; i < 4; i++) do_slot(3, '0, '0, '0, '0, '0);
    rom_lat = 3;
    do_slot(3, 4'b0100, 4'b0000, 18'h05555, 18'h05557, 4'hC);
    drain(3);
    // Start and stop together on channel 2: stop wins
    do_slot(3, 4'b0100, 4'b0100, 18'h06000, 18'h06004, 4'h1);
    chk("startstop_busy2", busy[2], 1'b0);
    for (int i = 0; i < 5; i++) do_slot(3, '0, '0, '0, '0, '0);

    // Random traffic
    for (int i = 0; i < 700; i++) begin
      if (i % 50 == 0) rom_lat = $urandom_range(1, 6);
      n = $urandom_range(0, 15);
      k = $urandom_range(0, 3);
      len = $urandom_range(0, 5);
      sa = 18'($urandom);
      bits = 4'(1 << k);
      if (n < 3)       do_slot($urandom_range(0, 5), bits, 4'b0000, sa, sa + 18'(len), 4'($urandom));
      else if (n == 3) do_slot($urandom_range(0, 5), 4'b0000, bits, '0, '0, '0);
      else if (n == 4) do_slot($urandom_range(0, 5), bits, bits, sa, sa + 18'(len), 4'($urandom));
      else             do_slot($urandom_range(0, 5), '0, '0, '0, '0, '0);
    end
    rom_lat = 2;
    drain(3);

    // Reset while a request is outstanding
    rom_lat = 20;
    do_slot(3, 4'b0010, 4'b0000, 18'h07000, 18'h07005, 4'h6);
    n = 0;
    while (!rom_cs && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_before_reset", rom_cs, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) do_slot(3, '0, '0, '0, '0, '0);
    chk("post_reset_rom_cs", rom_cs, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
